// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage sitting between execute and writeback.
// Turns the ALU result into a data-memory address (or passes it through for
// non-memory ops), runs a req/ack transaction on the data-memory port with
// little-endian byte/halfword/word formatting, and hands a registered result
// to writeback. Execute is stalled while a transaction is outstanding.
//
// Optional build macro: MEM_TIMEOUT_EN
//   Defined   - an ack watchdog aborts a request after TIMEOUT_CYCLES cycles
//               without ack and pulses mem_timeout_out.
//   Undefined - a request waits for ack indefinitely; mem_timeout_out is 0.
module mem_access_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // execute side
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [1:0]                ex_mem_op,
  input  logic [1:0]                ex_size,
  input  logic                      ex_signed,
  input  logic [DATA_WIDTH-1:0]     ex_alu_result,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_reg_we,
  // data-memory port
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [ADDR_WIDTH-1:0]     dmem_addr,
  output logic [3:0]                dmem_be,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic                      dmem_ack,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  // writeback side
  output logic                      wb_valid,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic                      wb_we,
  // status pulses
  output logic                      mem_misalign_out,
  output logic                      mem_timeout_out
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  state_t state_q, state_d;

  // Request fields presented to memory, held for the whole transaction
  logic                      dmemWe_q;
  logic [ADDR_WIDTH-1:0]     dmemAddr_q;
  logic [3:0]                dmemBe_q;
  logic [DATA_WIDTH-1:0]     dmemWdata_q;

  // Op context kept alive across the transaction for the writeback result
  logic [REG_ADDR_WIDTH-1:0] rdHold_q;
  logic                      regWeHold_q;
  logic                      isLoad_q;
  logic [1:0]                size_q;
  logic                      signed_q;
  logic [1:0]                lane_q;

  // Writeback result registers
  logic                      wbValid_q, wbValid_d;
  logic [DATA_WIDTH-1:0]     wbData_q, wbData_d;
  logic [REG_ADDR_WIDTH-1:0] wbRd_q, wbRd_d;
  logic                      wbWe_q, wbWe_d;
  logic                      misalign_q, misalign_d;

  // Decode of the op currently offered by execute
  logic                      accept;
  logic                      isLoadOp;
  logic                      isStoreOp;
  logic                      isMemOp;
  logic [1:0]                addrLane;
  logic                      misaligned;
  logic                      launch;
  logic [3:0]                beFmt;
  logic [DATA_WIDTH-1:0]     wdataFmt;

  // Load formatting of the returned word
  logic [DATA_WIDTH-1:0]     loadShift;
  logic [DATA_WIDTH-1:0]     loadData;

  assign accept     = ex_valid && (state_q == IDLE);
  assign isLoadOp   = (ex_mem_op == OP_LOAD);
  assign isStoreOp  = (ex_mem_op == OP_STORE);
  assign isMemOp    = isLoadOp || isStoreOp;
  assign addrLane   = ex_alu_result[1:0];
  // Halfwords need an even address, words need a 4-byte aligned one
  assign misaligned = ((ex_size == SIZE_HALF) && addrLane[0]) ||
                      (ex_size[1] && (addrLane != 2'b00));

  // Byte enables and lane-replicated write data for the offered op
  always_comb begin
    beFmt    = 4'b1111;
    wdataFmt = ex_store_data;
    case (ex_size)
      SIZE_BYTE: begin
        beFmt    = 4'b0001 << addrLane;
        wdataFmt = {4{ex_store_data[7:0]}};
      end
      SIZE_HALF: begin
        beFmt    = 4'b0011 << addrLane;
        wdataFmt = {2{ex_store_data[15:0]}};
      end
      default: begin
        beFmt    = 4'b1111;
        wdataFmt = ex_store_data;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0 and extend it to a full word
  always_comb begin
    loadShift = dmem_rdata >> {lane_q, 3'b000};
    loadData  = dmem_rdata;
    case (size_q)
      SIZE_BYTE: loadData = {{(DATA_WIDTH-8){signed_q & loadShift[7]}}, loadShift[7:0]};
      SIZE_HALF: loadData = {{(DATA_WIDTH-16){signed_q & loadShift[15]}}, loadShift[15:0]};
      default:   loadData = dmem_rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmoCnt_q, tmoCnt_d;
  logic             tmoHit;
  logic             timeout_q, timeout_d;

  // Watchdog count: cleared when a request starts, advanced on every unanswered REQ cycle
  always_comb begin
    tmoCnt_d = tmoCnt_q;
    if (launch) begin
      tmoCnt_d = '0;
    end else if ((state_q == REQ) && !dmem_ack) begin
      tmoCnt_d = tmoCnt_q + 1'b1;
    end
  end

  // An ack in the limit cycle takes priority, so the hit requires no ack
  assign tmoHit = (state_q == REQ) && !dmem_ack && (tmoCnt_q == TMO_LIMIT);

  // Watchdog counter and timeout pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmoCnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmoCnt_q  <= tmoCnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_timeout_out = timeout_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign mem_timeout_out = 1'b0;
`endif

  // Next state and writeback result; the result registers only pulse valid
  always_comb begin
    state_d    = state_q;
    launch     = 1'b0;
    wbValid_d  = 1'b0;
    wbData_d   = wbData_q;
    wbRd_d     = wbRd_q;
    wbWe_d     = 1'b0;
    misalign_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!isMemOp) begin
            wbValid_d = 1'b1;
            wbData_d  = ex_alu_result;
            wbRd_d    = ex_rd;
            wbWe_d    = ex_reg_we;
          end else if (misaligned) begin
            wbValid_d  = 1'b1;
            wbData_d   = '0;
            wbRd_d     = ex_rd;
            wbWe_d     = 1'b0;
            misalign_d = 1'b1;
          end else begin
            launch  = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_ack) begin
          state_d   = IDLE;
          wbValid_d = 1'b1;
          wbRd_d    = rdHold_q;
          wbWe_d    = isLoad_q && regWeHold_q;
          wbData_d  = isLoad_q ? loadData : '0;
`ifdef MEM_TIMEOUT_EN
        end else if (tmoHit) begin
          state_d   = IDLE;
          wbValid_d = 1'b1;
          wbRd_d    = rdHold_q;
          wbWe_d    = 1'b0;
          wbData_d  = '0;
          timeout_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the formatted request and op context when a request launches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmemWe_q    <= 1'b0;
      dmemAddr_q  <= '0;
      dmemBe_q    <= 4'b0000;
      dmemWdata_q <= '0;
      rdHold_q    <= '0;
      regWeHold_q <= 1'b0;
      isLoad_q    <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      lane_q      <= 2'b00;
    end else if (launch) begin
      dmemWe_q    <= isStoreOp;
      dmemAddr_q  <= {ex_alu_result[ADDR_WIDTH-1:2], 2'b00};
      dmemBe_q    <= beFmt;
      dmemWdata_q <= wdataFmt;
      rdHold_q    <= ex_rd;
      regWeHold_q <= ex_reg_we;
      isLoad_q    <= isLoadOp;
      size_q      <= ex_size;
      signed_q    <= ex_signed;
      lane_q      <= addrLane;
    end
  end

  // Writeback result and misalign pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbValid_q  <= 1'b0;
      wbData_q   <= '0;
      wbRd_q     <= '0;
      wbWe_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      wbValid_q  <= wbValid_d;
      wbData_q   <= wbData_d;
      wbRd_q     <= wbRd_d;
      wbWe_q     <= wbWe_d;
      misalign_q <= misalign_d;
    end
  end

  assign ex_ready         = (state_q == IDLE);
  assign dmem_req         = (state_q == REQ);
  assign dmem_we          = dmemWe_q;
  assign dmem_addr        = dmemAddr_q;
  assign dmem_be          = dmemBe_q;
  assign dmem_wdata       = dmemWdata_q;
  assign wb_valid         = wbValid_q;
  assign wb_data          = wbData_q;
  assign wb_rd            = wbRd_q;
  assign wb_we            = wbWe_q;
  assign mem_misalign_out = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed scenarios plus randomized traffic,
// checked by a scoreboard against a byte-addressed memory model.
module tb_mem_access_stage;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;
`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid = 1'b0;
  logic          ex_ready;
  logic [1:0]    ex_mem_op = 2'b00;
  logic [1:0]    ex_size = 2'b00;
  logic          ex_signed = 1'b0;
  logic [DW-1:0] ex_alu_result = '0;
  logic [DW-1:0] ex_store_data = '0;
  logic [RW-1:0] ex_rd = '0;
  logic          ex_reg_we = 1'b0;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [3:0]    dmem_be;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack = 1'b0;
  logic [DW-1:0] dmem_rdata = '0;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic [RW-1:0] wb_rd;
  logic          wb_we;
  logic          mem_misalign_out;
  logic          mem_timeout_out;

  mem_access_stage #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_mem_op(ex_mem_op),
    .ex_size(ex_size), .ex_signed(ex_signed), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
    .mem_misalign_out(mem_misalign_out), .mem_timeout_out(mem_timeout_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        mis;
    logic        tmo;
    bit          dataCare;
    bit          rdCare;
  } wbExp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          wdCare;
    int          waitCycles;
  } reqExp_t;

  wbExp_t  wbQ[$];
  reqExp_t reqQ[$];
  logic [7:0] tbMem [64];

  int checks = 0;
  int passes = 0;
  bit spuriousAck = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Byte count of an access size: byte, half, word
  function automatic int sizeBytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  // Little-endian read of the model memory, extended to 32 bits
  function automatic logic [31:0] modelLoad(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
    logic [31:0] off = addr - BASE;
    logic [31:0] v = 0;
    logic [31:0] mask;
    int n = sizeBytes(size);
    for (int k = 0; k < n; k++) v = v | (32'(tbMem[off + k]) << (8 * k));
    if (n < 4) begin
      mask = (32'h1 << (8 * n)) - 32'h1;
      if (sgn && v[8 * n - 1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [31:0] readWord(input logic [31:0] a);
    logic [31:0] off = a - BASE;
    if (off <= 32'd60 && off[1:0] == 2'b00)
      return {tbMem[off + 3], tbMem[off + 2], tbMem[off + 1], tbMem[off]};
    return 32'hDEAD_BEEF;
  endfunction

  // Offer one op, compute its expected outcome, and return at the negedge after acceptance
  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                               input logic [31:0] alu, input logic [31:0] sd,
                               input logic [4:0] rd, input logic we, input int waitCycles);
    int guard = 0;
    bit isMem = (op == 2'b01) || (op == 2'b10);
    bit mis;
    bit tmoExp;
    int n = sizeBytes(size);
    wbExp_t e;
    reqExp_t r;
    logic [31:0] off;
    mis = isMem && ((size == 2'b01 && alu[0]) || (size[1] && alu[1:0] != 2'b00));
    ex_valid = 1'b1; ex_mem_op = op; ex_size = size; ex_signed = sgn;
    ex_alu_result = alu; ex_store_data = sd; ex_rd = rd; ex_reg_we = we;
    while (!ex_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!ex_ready) begin
      check("readyWait", {31'b0, ex_ready}, 32'd1);
      ex_valid = 1'b0;
      return;
    end
    if (!isMem) begin
      e = '{alu, rd, we, 1'b0, 1'b0, 1, 1};
    end else if (mis) begin
      e = '{32'h0, rd, 1'b0, 1'b1, 1'b0, 1, 0};
    end else begin
      off = alu - BASE;
      r.we = (op == 2'b10);
      r.addr = alu & ~32'h3;
      r.be = 4'b0000;
      for (int k = 0; k < n; k++) r.be[alu[1:0] + k] = 1'b1;
      r.wdata = (n == 1) ? sd[7:0] * 32'h0101_0101 : (n == 2) ? sd[15:0] * 32'h0001_0001 : sd;
      r.wdCare = r.we;
      r.waitCycles = waitCycles;
      reqQ.push_back(r);
`ifdef MEM_TIMEOUT_EN
      tmoExp = (waitCycles < 0) || (waitCycles >= TMO);
`else
      tmoExp = 0;
`endif
      if (tmoExp) e = '{32'h0, rd, 1'b0, 1'b0, 1'b1, 0, 0};
      else if (op == 2'b01) e = '{modelLoad(alu, size, sgn), rd, we, 1'b0, 1'b0, 1, 1};
      else begin
        e = '{32'h0, rd, 1'b0, 1'b0, 1'b0, 1, 1};
        for (int k = 0; k < n; k++) tbMem[off + k] = sd[8 * k +: 8];
      end
    end
    wbQ.push_back(e);
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  // Scoreboard monitor: compare every writeback pulse with the oldest expectation
  task automatic checkOutput();
    wbExp_t e;
    if (wb_valid) begin
      if (wbQ.size() == 0) begin
        check("wbUnexpected", {31'b0, wb_valid}, 32'd0);
      end else begin
        e = wbQ.pop_front();
        if (e.dataCare) check("wbData", wb_data, e.data);
        if (e.rdCare) check("wbRd", {27'b0, wb_rd}, {27'b0, e.rd});
        check("wbWe", {31'b0, wb_we}, {31'b0, e.we});
        check("misalignFlag", {31'b0, mem_misalign_out}, {31'b0, e.mis});
        check("timeoutFlag", {31'b0, mem_timeout_out}, {31'b0, e.tmo});
      end
    end else if (mem_misalign_out || mem_timeout_out) begin
      check("strayPulse", {30'b0, mem_misalign_out, mem_timeout_out}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) checkOutput();
  end

  // Memory responder: checks each request and acks after the planned wait
  reqExp_t curReq;
  bit active = 0;
  int waitLeft = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 0;
      dmem_ack = 1'b0;
    end else if (dmem_req) begin
      if (!active) begin
        active = 1;
        if (reqQ.size() == 0) begin
          check("reqUnexpected", {31'b0, dmem_req}, 32'd0);
          curReq = '{1'b0, dmem_addr, dmem_be, dmem_wdata, 0, 0};
        end else begin
          curReq = reqQ.pop_front();
          check("reqWe", {31'b0, dmem_we}, {31'b0, curReq.we});
          check("reqAddr", dmem_addr, curReq.addr);
          check("reqBe", {28'b0, dmem_be}, {28'b0, curReq.be});
          if (curReq.wdCare) check("reqWdata", dmem_wdata, curReq.wdata);
        end
        waitLeft = curReq.waitCycles;
      end else begin
        check("reqAddrStable", dmem_addr, curReq.addr);
        check("reqBeStable", {28'b0, dmem_be}, {28'b0, curReq.be});
      end
      if (waitLeft == 0) begin
        dmem_ack = 1'b1;
        dmem_rdata = readWord(dmem_addr);
      end else begin
        dmem_ack = 1'b0;
        dmem_rdata = $urandom;
        waitLeft--;
      end
    end else begin
      active = 0;
      dmem_ack = spuriousAck ? 1'($urandom_range(0, 1)) : 1'b0;
      dmem_rdata = $urandom;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    int tmoSeen;
    for (int i = 0; i < 64; i++) tbMem[i] = 8'($urandom);

    // Reset state
    #3;
    check("rstReady", {31'b0, ex_ready}, 32'd1);
    check("rstReq", {31'b0, dmem_req}, 32'd0);
    check("rstWbValid", {31'b0, wb_valid}, 32'd0);
    check("rstWbData", wb_data, 32'd0);
    check("rstBe", {28'b0, dmem_be}, 32'd0);
    check("rstPulses", {30'b0, mem_misalign_out, mem_timeout_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of an unanswered request
    applyStimulus(2'b01, 2'b10, 1'b0, BASE + 32'h8, 32'h0, 5'd3, 1'b1, -1);
    check("midReqHigh", {31'b0, dmem_req}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midRstReq", {31'b0, dmem_req}, 32'd0);
    check("midRstReady", {31'b0, ex_ready}, 32'd1);
    check("midRstWbValid", {31'b0, wb_valid}, 32'd0);
    wbQ.delete();
    reqQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, 1'b0, 32'h1234, 32'h0, 5'd7, 1'b1, 0);
    check("nonMemLatency", {31'b0, wb_valid}, 32'd1);
    check("nonMemData", wb_data, 32'h0000_1234);

    // Signed byte load at 0x103, ack on first REQ cycle
    tbMem[0] = 8'hCC; tbMem[1] = 8'hBB; tbMem[2] = 8'hAA; tbMem[3] = 8'h80;
    applyStimulus(2'b01, 2'b00, 1'b1, 32'h103, 32'h0, 5'd9, 1'b1, 0);
    check("sbBe", {28'b0, dmem_be}, 32'h8);
    check("sbNotYet", {31'b0, wb_valid}, 32'd0);
    @(negedge clk);
    check("sbLatency", {31'b0, wb_valid}, 32'd1);
    check("sbData", wb_data, 32'hFFFF_FF80);

    // Unsigned half load at 0x102 with three wait cycles
    tbMem[0] = 8'h00; tbMem[1] = 8'h00; tbMem[2] = 8'h01; tbMem[3] = 8'h80;
    applyStimulus(2'b01, 2'b01, 1'b0, 32'h102, 32'h0, 5'd4, 1'b1, 3);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (!ex_ready && dmem_req) cnt++;
    end
    check("halfStallCycles", cnt, 32'd4);
    @(negedge clk);
    check("halfWbValid", {31'b0, wb_valid}, 32'd1);
    check("halfData", wb_data, 32'h0000_8001);
    check("halfReadyAgain", {31'b0, ex_ready}, 32'd1);

    // Byte store at 0x101
    applyStimulus(2'b10, 2'b00, 1'b0, 32'h101, 32'h0000_00A5, 5'd2, 1'b1, 1);
    check("stWe", {31'b0, dmem_we}, 32'd1);
    check("stBe", {28'b0, dmem_be}, 32'h2);
    check("stWdata", dmem_wdata, 32'hA5A5_A5A5);
    check("stAddr", dmem_addr, 32'h100);
    repeat (3) @(negedge clk);

    // Misaligned word load
    applyStimulus(2'b01, 2'b10, 1'b0, 32'h102, 32'h0, 5'd5, 1'b1, 0);
    check("misPulse", {31'b0, mem_misalign_out}, 32'd1);
    check("misNoReq", {31'b0, dmem_req}, 32'd0);
    check("misWe", {31'b0, wb_we}, 32'd0);
    @(negedge clk);
    check("misPulseEnd", {31'b0, mem_misalign_out}, 32'd0);

    // Back-to-back pass-through ops
    for (int i = 0; i < 4; i++)
      applyStimulus(2'($urandom_range(0, 1) * 3), 2'b00, 1'b0, $urandom, 32'h0, 5'($urandom), 1'b1, 0);

`ifdef MEM_TIMEOUT_EN
    // Never-acked request is aborted after the watchdog limit
    applyStimulus(2'b01, 2'b10, 1'b0, BASE + 32'h10, 32'h0, 5'd6, 1'b1, -1);
    cnt = 0; tmoSeen = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (dmem_req) cnt++;
      if (mem_timeout_out) tmoSeen++;
    end
    check("tmoReqCycles", cnt, 32'd4);
    check("tmoPulses", tmoSeen, 32'd1);
    // Ack in the limit cycle completes normally
    applyStimulus(2'b01, 2'b10, 1'b0, BASE + 32'h14, 32'h0, 5'd8, 1'b1, 3);
    repeat (6) @(negedge clk);
`else
    tmoSeen = 0;
`endif

    // Randomized traffic with spurious idle acks
    spuriousAck = 1;
    for (int i = 0; i < 150; i++) begin
      logic [1:0] op = 2'($urandom_range(0, 3));
      logic [31:0] alu = (op == 2'b01 || op == 2'b10) ? BASE + 32'($urandom_range(0, 63)) : $urandom;
      applyStimulus(op, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), alu, $urandom,
                    5'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    spuriousAck = 0;

    cnt = 0;
    while ((wbQ.size() != 0 || reqQ.size() != 0) && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("drainWb", wbQ.size(), 32'd0);
    check("drainReq", reqQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the execute ALU. Takes the ALU result as a memory address or pass-through value, plus store data, from execute.
- Runs a req/ack transaction on the data-memory port. Formats byte, halfword and word loads and stores (little-endian lanes).
- Presents a registered result to writeback and stalls execute while a memory transaction is outstanding.

Parameters:
- DATA_WIDTH, 32, datapath width; lane logic is defined only for 32.
- ADDR_WIDTH, 32, data-memory address width.
- REG_ADDR_WIDTH, 5, destination register index width.
- TIMEOUT_CYCLES, 255, ack watchdog limit; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute presents an op.
- ex_ready  out  1  stage can accept; equals (state==IDLE).
- ex_mem_op  in  2  00 none, 01 load, 10 store, 11 treated as none.
- ex_size  in  2  00 byte, 01 half, 10/11 word.
- ex_signed  in  1  sign-extend loads.
- ex_alu_result  in  DATA_WIDTH  address for mem ops, result otherwise.
- ex_store_data  in  DATA_WIDTH  store source, right-aligned.
- ex_rd  in  REG_ADDR_WIDTH  destination register.
- ex_reg_we  in  1  op writes a register.
- dmem_req  out  1  request, held until ack.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_WIDTH  word-aligned address ({addr[ADDR_WIDTH-1:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  DATA_WIDTH  lane-replicated write data.
- dmem_ack  in  1  transaction complete; rdata valid in the same cycle.
- dmem_rdata  in  DATA_WIDTH  read word.
- wb_valid  out  1  one-cycle result pulse.
- wb_data  out  DATA_WIDTH  result.
- wb_rd  out  REG_ADDR_WIDTH  destination register.
- wb_we  out  1  register write enable.
- mem_misalign_out  out  1  one-cycle pulse on a misaligned access.
- mem_timeout_out  out  1  one-cycle pulse on a watchdog abort.

Behaviour:
- Reset: state IDLE. All outputs 0 except ex_ready=1. Reset mid-transaction abandons it; dmem_req drops asynchronously.
- FSM states: IDLE and REQ. An op is accepted when ex_valid && ex_ready.
- Non-mem op accepted: next cycle wb_valid=1, wb_data=ex_alu_result, wb_rd=ex_rd, wb_we=ex_reg_we. Latency 1; back-to-back ops sustained every cycle.
- Alignment rule: half needs addr[0]=0; word needs addr[1:0]=00.
- Mem op, aligned: next cycle state=REQ and dmem_req=1. dmem_we, dmem_addr, dmem_be and dmem_wdata are registered and held stable until dmem_ack.
- Mem op, misaligned: no request is issued. Next cycle: mem_misalign_out=1, wb_valid=1, wb_we=0, wb_data=0.
- Byte enables: byte → 4'b0001<<addr[1:0]; half → 4'b0011<<addr[1:0]; word → 4'b1111.
- Write data: byte → {4{sd[7:0]}}; half → {2{sd[15:0]}}; word → sd.
- REQ with dmem_ack=1 (first cycle possible): state→IDLE. Next cycle wb_valid=1, wb_rd=latched rd.
  - Load: wb_we=latched reg_we. wb_data is the selected lane shifted down, then sign- or zero-extended per ex_signed.
  - Store: wb_we=0, wb_data=0.
- Load latency with a zero-wait ack: 2 cycles from acceptance to wb_valid.
- ex_ready goes low in the cycle after acceptance of an aligned mem op and stays low through the ack cycle. ex_ready is 1 in the cycle wb_valid is asserted, so a new op may be accepted that cycle.
- dmem_ack while in IDLE is ignored.
- dmem_rdata is sampled only in the ack cycle.
- All wb_* outputs are registered; wb_valid is a single-cycle pulse.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - At count==TIMEOUT_CYCLES-1 with no ack: dmem_req drops and state→IDLE.
  - Next cycle: mem_timeout_out=1, wb_valid=1, wb_we=0.
  - An ack arriving in the same cycle as the limit wins; no timeout is raised.
- Undefined: no counter; REQ waits indefinitely; mem_timeout_out tied 0.

Test Plan:
- Reset mid-REQ (req asserted, no ack) → dmem_req=0 immediately, ex_ready=1, wb_valid=0. After release, a non-mem op with ex_alu_result=0x1234 → wb_data=0x1234 one cycle later.
- Signed byte load, addr=0x103, ack on first REQ cycle, rdata=0x80AABBCC → be=0001<<3 on request, wb_data=0xFFFFFF80 two cycles after acceptance.
- Unsigned half load, addr=0x102, ack after 3 wait cycles, rdata=0x8001_0000 → wb_data=0x00008001. ex_ready low for all 4 REQ cycles.
- Byte store, addr=0x101, sd=0x000000A5 → dmem_we=1, be=0010, wdata=0xA5A5A5A5, addr=0x100. wb_valid with wb_we=0.
- Word load at addr=0x102 → no dmem_req, mem_misalign_out=1 for one cycle, wb_we=0.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, never ack → req high exactly 4 cycles, then mem_timeout_out pulse. Repeat with ack on the 4th cycle → normal completion, no timeout.
